// File: rtl/im_pkg.sv
// Shared constants, state encoding and PC helpers for the instruction-memory fetch path.
// Pure declarations: no logic, no timing, no flow control.
package im_pkg;

    localparam logic [31:0] PC_BASE = 32'h0000_3000;
    localparam int          IM_AW   = 12;
    localparam int          QDEPTH  = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic logic [IM_AW-1:0] pc_to_idx(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - PC_BASE;
        return off[IM_AW+1:2];
    endfunction

    // 33-bit offset so that pc below PC_BASE shows up as a borrow instead of wrapping
    function automatic logic pc_in_range(input logic [31:0] pc);
        logic [32:0] off;
        off = {1'b0, pc} - {1'b0, PC_BASE};
        return (pc[1:0] == 2'b00) && !off[32] && (off < (33'd1 << (IM_AW + 2)));
    endfunction

endpackage

// File: rtl/im_fetch_queue.sv
// Two-entry {pc, instr} queue; head is a register, so a push is visible one cycle later.
// Caller only pushes when not full or when popping in the same cycle; flush empties it at once.
module im_fetch_queue
    import im_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] push_dat,
    output logic        head_vld,
    output logic        full,
    output logic [63:0] head_dat
);

    logic [63:0] ent0_q, ent0_d;
    logic [63:0] ent1_q, ent1_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_d = push_dat;
                    else               ent1_d = push_dat;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the new word lands behind whatever remains
                    if (cnt_q == 2'(QDEPTH)) begin
                        ent0_d = ent1_q;
                        ent1_d = push_dat;
                    end else begin
                        ent0_d = push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_vld = (cnt_q != 2'd0);
    assign full     = (cnt_q == 2'(QDEPTH));
    assign head_dat = ent0_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// PC sequencer sharing one combinational IM read port between fetch and debug; first word
// reaches decode one cycle after its fetch. Fetch stalls while the queue is full and unpopped.
module im_fetch_ctrl
    import im_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             dbg_req,
    input  logic [IM_AW-1:0] dbg_addr,
    output logic             dbg_ack,
    output logic [31:0]      dbg_data,
    output logic             fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_inc;
    logic         last_dbg_q, last_dbg_d;
    logic         dbg_ack_q, dbg_ack_d;
    logic [31:0]  dbg_data_q, dbg_data_d;
    logic         q_vld, q_full, pop, push;
    logic         fetch_elig, dbg_gnt, fetch_gnt;
    fq_entry_t    head, push_ent;

    assign pc_inc = pc_q + 32'd4;
    assign pop    = q_vld & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid)
            state_d = pc_in_range(redirect_pc) ? RUN : FAULT;
        else if (fetch_gnt && !pc_in_range(pc_inc))
            state_d = FAULT;
    end

    // Debug normally wins; after a debug grant an eligible fetch gets the next slot.
    always_comb begin
        fault      = (state_q == FAULT);
        fetch_elig = (state_q == RUN) && (!q_full || pop);
        dbg_gnt    = dbg_req && !(last_dbg_q && fetch_elig);
        fetch_gnt  = fetch_elig && !dbg_gnt;
        push       = fetch_gnt && !redirect_valid;
        im_addr    = dbg_gnt ? dbg_addr : pc_to_idx(pc_q);
    end

    always_comb begin
        pc_d       = pc_q;
        last_dbg_d = dbg_gnt;
        dbg_ack_d  = dbg_gnt;
        dbg_data_d = dbg_gnt ? im_instr : dbg_data_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (fetch_gnt) pc_d = pc_inc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= PC_BASE;
            last_dbg_q <= 1'b0;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            pc_q       <= pc_d;
            last_dbg_q <= last_dbg_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign push_ent = '{pc: pc_q, instr: im_instr};

    im_fetch_queue u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_dat (push_ent),
        .head_vld (q_vld),
        .full     (q_full),
        .head_dat (head)
    );

    assign out_valid = q_vld;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl with a queue-based reference model checked every cycle.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] im_addr;
    logic [31:0] im_instr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        dbg_req = 1'b0;
    logic [11:0] dbg_addr = 12'd0;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // IM contents: word k holds 0x1000_0000 + k
    assign im_instr = 32'h1000_0000 + {20'd0, im_addr};

    im_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_ack        (dbg_ack),
        .dbg_data       (dbg_data),
        .fault          (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        return (a >= 32'h3000) && (a <= 32'h6FFC) && (lo == 2'b00);
    endfunction

    function automatic logic [11:0] word_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'h3000) / 4;
        return w[11:0];
    endfunction

    // Reference model: PC, fault flag, SV queue of {pc, instr}, debug bookkeeping
    logic [31:0] m_pc;
    bit          m_fault, m_last_dbg, m_ack;
    logic [31:0] m_data;
    logic [63:0] m_q[$];
    logic [63:0] m_head;
    int          m_n;
    bit          m_pop, m_elig, m_dg, m_fg;
    logic [11:0] m_addr;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_pc = 32'h3000; m_fault = 0; m_last_dbg = 0; m_ack = 0; m_data = 32'd0;
                m_q.delete();
                chk1("rst_out_valid", out_valid, 1'b0);
                chk("rst_out_instr", out_instr, 32'd0);
                chk("rst_out_pc", out_pc, 32'd0);
                chk1("rst_dbg_ack", dbg_ack, 1'b0);
                chk("rst_dbg_data", dbg_data, 32'd0);
                chk1("rst_fault", fault, 1'b0);
            end else begin
                m_n = m_q.size();
                chk1("m_out_valid", out_valid, m_n > 0);
                chk1("m_fault", fault, m_fault);
                chk1("m_dbg_ack", dbg_ack, m_ack);
                chk("m_dbg_data", dbg_data, m_data);
                if (m_n > 0) begin
                    m_head = m_q[0];
                    chk("m_out_pc", out_pc, m_head[63:32]);
                    chk("m_out_instr", out_instr, m_head[31:0]);
                end
                m_pop  = (m_n > 0) && out_ready;
                m_elig = !m_fault && ((m_n < 2) || m_pop);
                m_dg   = dbg_req && !(m_last_dbg && m_elig);
                m_fg   = m_elig && !m_dg;
                m_addr = m_dg ? dbg_addr : word_of(m_pc);
                if (m_dg || m_fg) chk("m_im_addr", {20'd0, im_addr}, {20'd0, m_addr});
                if (m_pop) void'(m_q.pop_front());
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc    = redirect_pc;
                    m_fault = !in_window(redirect_pc);
                end else if (m_fg) begin
                    m_q.push_back({m_pc, 32'h1000_0000 + {20'd0, word_of(m_pc)}});
                    m_pc = m_pc + 32'd4;
                    if (!in_window(m_pc)) m_fault = 1;
                end
                m_ack = m_dg;
                if (m_dg) m_data = 32'h1000_0000 + {20'd0, dbg_addr};
                m_last_dbg = m_dg;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bad_pc [3] = '{32'h3002, 32'h2FFC, 32'h7000};

    initial begin
        // Scenario 1: free-running fetch after reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); chk1("s1_c0_valid", out_valid, 1'b0);
        tick(); @(negedge clk);
        chk1("s1_c1_valid", out_valid, 1'b1);
        chk("s1_pc0", out_pc, 32'h3000); chk("s1_in0", out_instr, 32'h1000_0000);
        tick(); @(negedge clk);
        chk("s1_pc1", out_pc, 32'h3004); chk("s1_in1", out_instr, 32'h1000_0001);
        tick(); @(negedge clk);
        chk("s1_pc2", out_pc, 32'h3008); chk("s1_in2", out_instr, 32'h1000_0002);

        // Reset in the ack cycle of a debug read must kill the ack
        tick(); dbg_req = 1'b1; dbg_addr = 12'd7;
        @(negedge clk);
        tick(); dbg_req = 1'b0; reset = 1'b1; out_ready = 1'b0;
        @(negedge clk); chk1("rst_mid_ack", dbg_ack, 1'b0);

        // Scenario 2: stall with decode not ready
        tick(); reset = 1'b0;
        @(negedge clk);
        repeat (4) tick();
        @(negedge clk);
        chk1("s2_full_valid", out_valid, 1'b1);
        chk("s2_head_pc", out_pc, 32'h3000);
        chk("s2_im_addr_held", {20'd0, im_addr}, 32'd2);
        tick(); out_ready = 1'b1;
        @(negedge clk); chk("s2_rel0", out_pc, 32'h3000);
        tick(); @(negedge clk); chk("s2_rel1", out_pc, 32'h3004);
        tick(); @(negedge clk); chk("s2_rel2", out_pc, 32'h3008);

        // Scenario 3: redirect while full
        tick(); out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h3040;
        @(negedge clk);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk1("s3_bubble", out_valid, 1'b0);
        tick(); @(negedge clk);
        chk1("s3_valid", out_valid, 1'b1);
        chk("s3_pc", out_pc, 32'h3040); chk("s3_instr", out_instr, 32'h1000_0010);

        // Scenario 4: out-of-range redirects, then recovery
        for (int i = 0; i < 3; i++) begin
            tick(); redirect_valid = 1'b1; redirect_pc = bad_pc[i];
            @(negedge clk);
            tick(); redirect_valid = 1'b0;
            @(negedge clk);
            chk1("s4_fault", fault, 1'b1); chk1("s4_valid", out_valid, 1'b0);
            tick(); @(negedge clk); chk1("s4_valid_hold", out_valid, 1'b0);
        end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h3100;
        @(negedge clk);
        tick(); redirect_valid = 1'b0;
        @(negedge clk); chk1("s4_clear", fault, 1'b0); chk1("s4_bubble", out_valid, 1'b0);
        tick(); @(negedge clk);
        chk("s4_pc", out_pc, 32'h3100); chk("s4_instr", out_instr, 32'h1000_0040);

        // Scenario 5: held debug request alternates with fetch
        tick(); dbg_req = 1'b1; dbg_addr = 12'd5;
        @(negedge clk); chk("s5_dbg_addr", {20'd0, im_addr}, 32'd5);
        tick(); @(negedge clk);
        chk1("s5_ack", dbg_ack, 1'b1); chk("s5_data", dbg_data, 32'h1000_0005);
        chk("s5_fetch_addr", {20'd0, im_addr}, 32'h42);
        tick(); @(negedge clk); chk("s5_dbg_addr2", {20'd0, im_addr}, 32'd5);
        repeat (5) tick();
        dbg_req = 1'b0;
        repeat (3) tick();

        // Scenario 6: run off the end of the IM window
        redirect_valid = 1'b1; redirect_pc = 32'h6FF8;
        @(negedge clk);
        tick(); redirect_valid = 1'b0;
        @(negedge clk); chk1("s6_bubble", out_valid, 1'b0);
        tick(); @(negedge clk);
        chk("s6_pc0", out_pc, 32'h6FF8); chk("s6_in0", out_instr, 32'h1000_0FFE);
        chk1("s6_fault0", fault, 1'b0);
        tick(); @(negedge clk);
        chk("s6_pc1", out_pc, 32'h6FFC); chk("s6_in1", out_instr, 32'h1000_0FFF);
        chk1("s6_fault1", fault, 1'b1); chk1("s6_valid1", out_valid, 1'b1);
        tick(); @(negedge clk);
        chk1("s6_drained", out_valid, 1'b0); chk1("s6_fault2", fault, 1'b1);
        tick(); dbg_req = 1'b1; dbg_addr = 12'hFFF;
        @(negedge clk); chk("s6_dbg_addr", {20'd0, im_addr}, 32'hFFF);
        tick(); dbg_req = 1'b0;
        @(negedge clk);
        chk1("s6_dbg_ack", dbg_ack, 1'b1); chk("s6_dbg_data", dbg_data, 32'h1000_0FFF);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
